// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and constants for the multicycle control sequencer.
package seq_pkg;

  // Wait-counter width used by the memory timeout timer
  localparam int unsigned WAIT_W = 8;

  // Registered FSM state; the encoding is visible on the debug state port
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } state_t;

  // Single-step pause shares the IDLE code; a separate idle flag tells them apart
  localparam state_t ST_PAUSE = ST_IDLE;

  // Opcodes that change the instruction flow
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  // True for opcodes that need a data-memory access
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Control/handshake bundle between the sequencer (master) and datapath/memory (slave).
interface multicycle_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic [3:0]       opcode;
  logic             mem_ready;
  logic             pc_en;
  logic             ir_load;
  logic             reg_we;
  logic             mem_req;
  logic             mem_we;
  logic             mem_sel;
  logic             halted;
  logic             err;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, mem_ready,
    output pc_en, ir_load, reg_we, mem_req, mem_we, mem_sel,
    output halted, err, state, retired
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_en, ir_load, reg_we, mem_req, mem_we, mem_sel,
    input  halted, err, state, retired
  );
endinterface

// File: rtl/multicycle_sequencer_wait_timer.sv
// Memory wait timer shared by FETCH and MEM; flags the cycle whose wait reaches MEM_TIMEOUT.
module seq_wait_timer
  import seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [WAIT_W-1:0] count_q;

  // Count waiting cycles; clear has priority so a new access always starts from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + WAIT_W'(1);
    end
  end

  // This waiting cycle would bring the count to MEM_TIMEOUT
  assign expired = en && (count_q == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
// Optional single-step debug mode is enabled by defining SEQ_SINGLE_STEP_EN.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic CLOCK,
  input  logic CLEAR,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic step,
`endif
  multicycle_sequencer_if.master bus
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] retired_q;
  logic             in_access;
  logic             timer_clear;
  logic             timer_en;
  logic             expired;
  logic             sw_done;
  logic             retire;
  logic             pc_en;
  logic             ir_load;
  logic             reg_we;
  logic             mem_req;
  logic             mem_we;
  logic             mem_sel;
  logic             halted;
  logic             err;

`ifdef SEQ_SINGLE_STEP_EN
  localparam state_t RETIRE_NEXT = ST_PAUSE;
  logic idle_q;
  logic step_q1;
  logic step_q2;
  logic step_rise;

  // Register step and keep its previous value for rising-edge detection
  always_ff @(posedge CLOCK or posedge CLEAR) begin
    if (CLEAR) begin
      step_q1 <= 1'b0;
      step_q2 <= 1'b0;
    end else begin
      step_q1 <= step;
      step_q2 <= step_q1;
    end
  end

  assign step_rise = step_q1 & ~step_q2;

  // Idle flag is only set by reset; code 0 afterwards means PAUSE
  always_ff @(posedge CLOCK or posedge CLEAR) begin
    if (CLEAR) begin
      idle_q <= 1'b1;
    end else begin
      idle_q <= 1'b0;
    end
  end
`else
  localparam state_t RETIRE_NEXT = ST_FETCH;
`endif

  assign in_access   = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign timer_en    = in_access && !bus.mem_ready;
  assign timer_clear = !in_access || bus.mem_ready;
  assign sw_done     = (state_q == ST_MEM) && bus.mem_ready && (bus.opcode == OP_SW);
  assign retire      = (state_q == ST_WB) || sw_done;

  seq_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (CLOCK),
    .rst    (CLEAR),
    .clear  (timer_clear),
    .en     (timer_en),
    .expired(expired)
  );

  // State register
  always_ff @(posedge CLOCK or posedge CLEAR) begin
    if (CLEAR) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a ready response wins over a timeout in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
`ifdef SEQ_SINGLE_STEP_EN
        if (idle_q || step_rise) begin
          state_d = ST_FETCH;
        end
`else
        state_d = ST_FETCH;
`endif
      end
      ST_FETCH: begin
        if (bus.mem_ready) begin
          state_d = ST_DECODE;
        end else if (expired) begin
          state_d = ST_ERR;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (bus.opcode == OP_HALT) begin
          state_d = ST_HALT;
        end else if (is_mem_op(bus.opcode)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (bus.mem_ready) begin
          state_d = (bus.opcode == OP_SW) ? RETIRE_NEXT : ST_WB;
        end else if (expired) begin
          state_d = ST_ERR;
        end
      end
      ST_WB:   state_d = RETIRE_NEXT;
      ST_HALT: state_d = ST_HALT;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the registered state; only ir_load and SW completion see mem_ready
  always_comb begin
    pc_en   = 1'b0;
    ir_load = 1'b0;
    reg_we  = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    mem_sel = 1'b0;
    halted  = 1'b0;
    err     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_load = bus.mem_ready;
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (bus.opcode == OP_SW);
        pc_en   = sw_done;
      end
      ST_WB: begin
        reg_we = 1'b1;
        pc_en  = 1'b1;
      end
      ST_HALT: halted = 1'b1;
      ST_ERR:  err    = 1'b1;
      default: ;
    endcase
  end

  // Retired-instruction counter, wraps silently
  always_ff @(posedge CLOCK or posedge CLEAR) begin
    if (CLEAR) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.pc_en   = pc_en;
  assign bus.ir_load = ir_load;
  assign bus.reg_we  = reg_we;
  assign bus.mem_req = mem_req;
  assign bus.mem_we  = mem_we;
  assign bus.mem_sel = mem_sel;
  assign bus.halted  = halted;
  assign bus.err     = err;
  assign bus.state   = state_q;
  assign bus.retired = retired_q;

endmodule
